dma_reg_bank: RTL
=================

# dma_reg_bank

Register file of the DMA controller, directly downstream of the APB-to-register-interface stage. It decodes the flat register-interface strobes (address, write enable, read enable, byte mask, data) into DMA channel configuration. It issues single-cycle start/abort commands to the transfer engine, captures engine status into sticky flags, and drives a level interrupt. Read data is registered and presented for the APB access phase.

## Interface
- ADDR_W, 32: width of the source/destination address registers
- LEN_W, 24: width of the transfer length and byte-count fields
- VERSION, 32'h0001_0000: value returned by the VERSION register
- pclk  in  1: clock
- presetn  in  1: asynchronous active-low reset
- reg_addr  in  12: byte address, word-aligned; bits [1:0] ignored
- wr_en  in  1: write strobe, APB access phase, one cycle per transfer
- rd_en  in  1: read strobe, APB setup phase, one cycle per transfer
- wr_msk  in  4: byte enables for wr_data
- wr_data  in  32: write data
- rd_data  out  32: registered read data
- cfg_src  out  ADDR_W: source address
- cfg_dst  out  ADDR_W: destination address
- cfg_len  out  LEN_W: transfer length in bytes
- cfg_burst  out  4: burst length minus one (AXI len)
- dma_start  out  1: one-cycle start pulse to the engine
- dma_abort  out  1: one-cycle abort pulse to the engine
- dma_busy  in  1: engine busy level
- dma_done  in  1: one-cycle completion pulse
- dma_err  in  1: one-cycle bus-error pulse
- dma_bytes  in  LEN_W: bytes completed so far by the engine
- irq  out  1: registered interrupt, level

## Operation
- Register map (offset, access):
  - 0x000 CTRL. bit0 START (W, self-clearing, reads 0). bit1 ABORT (W, self-clearing, reads 0). bit2 IRQ_EN (RW). bits[7:4] BURST (RW).
  - 0x004 STATUS. bit0 BUSY (RO, mirrors dma_busy). bit1 DONE (W1C). bit2 ERR (W1C). bit3 CFG_ERR (W1C).
  - 0x008 SRC (RW). 0x00C DST (RW). 0x010 LEN (RW, bits[LEN_W-1:0]).
  - 0x014 XFER_CNT (RO, dma_bytes zero-extended). 0x018 VERSION (RO).
- Unmapped offsets: reads return 0, writes are ignored.
- RW fields honour wr_msk per byte. W1C and START/ABORT bits act only when their byte lane is enabled.
- Configuration lock: writes to SRC, DST, LEN and CTRL.BURST are dropped while dma_busy=1. IRQ_EN and ABORT stay writable.
- START write with dma_busy=0 and LEN≠0: dma_start=1 on the following cycle.
- START write with dma_busy=1 or LEN=0: no pulse; CFG_ERR is set instead.
- ABORT write with dma_busy=1: dma_abort=1 on the following cycle. With dma_busy=0 it is ignored.
- START and ABORT written in the same word: ABORT takes precedence and START is discarded.
- dma_done sets DONE. dma_err sets ERR.
- A hardware set coinciding with a W1C clear of the same bit: set wins.
- irq is registered: irq <= IRQ_EN & (DONE | ERR | CFG_ERR), evaluated on the current register values.
- Reset value of every output and register is 0, except rd_data, which is 0 until the first read.

## Timing
- Read: on a cycle with rd_en=1, rd_data loads the decoded value at the next edge. It holds until the next rd_en, so it is valid throughout the APB access phase. Zero wait states; pready is not generated here.
- Write: takes effect at the edge ending the wr_en cycle. A readback in the next APB transfer returns the new value.
- dma_start and dma_abort assert exactly one cycle, one cycle after the wr_en cycle. They never assert back-to-back from a single write.
- A flag set by dma_done/dma_err is readable when rd_en occurs at least one cycle after the pulse. irq follows the flag by one cycle.
- Reset asserted mid-transfer clears all state immediately, including pending pulses and flags. No pulse is emitted after presetn deasserts.
- wr_en and rd_en are never asserted in the same cycle. If they are, the write is performed and the read value is unspecified.

## Structure
- Shared package dma_reg_pkg holds:
  - register offset localparams (CTRL, STATUS, SRC, DST, LEN, XFER_CNT, VERSION)
  - CTRL/STATUS bit-position constants
  - the default VERSION constant
- The transfer engine and the testbench import the same package.
- Single flat module. A helper sub-module dma_w1c_flag (set input, clear input, set-wins, async reset) is natural and is instantiated for DONE, ERR and CFG_ERR.

## Test plan
- Reset, then read each of the 7 offsets: all 0 except VERSION = 32'h0001_0000. Unmapped 0x01C reads 0.
- Write SRC = 32'h1000_0000 with wr_msk = 4'b0011, then read back: 32'h0000_0000 lower lanes updated only. Full-mask write of 32'hDEAD_BEEF reads back 32'hDEAD_BEEF.
- LEN = 0x100, write CTRL = 0x05: one dma_start pulse. Hold dma_busy=1, then write SRC = 32'h1234: SRC is unchanged. Pulse dma_done: DONE=1, then irq=1. Write STATUS = 0x2: DONE=0 and irq drops.
- Write START with LEN=0: no dma_start, CFG_ERR=1. Write START while busy: no pulse, CFG_ERR=1.
- While busy, write CTRL = 0x03: dma_abort pulses once and dma_start does not.
- Drive dma_err in the same cycle as a W1C write of ERR: ERR reads 1. Assert presetn low mid-burst: every output is 0 within the reset assertion.

Source files
------------

// File: rtl/dma_reg_pkg.sv
// Shared definitions for the DMA register bank: register offsets, field positions and the
// version constant. The transfer engine and the testbench import this package as well.
package dma_reg_pkg;

   localparam logic [11:0] CtrlOffset    = 12'h000;
   localparam logic [11:0] StatusOffset  = 12'h004;
   localparam logic [11:0] SrcOffset     = 12'h008;
   localparam logic [11:0] DstOffset     = 12'h00C;
   localparam logic [11:0] LenOffset     = 12'h010;
   localparam logic [11:0] XferCntOffset = 12'h014;
   localparam logic [11:0] VersionOffset = 12'h018;

   localparam int unsigned CtrlStartBit = 0;
   localparam int unsigned CtrlAbortBit = 1;
   localparam int unsigned CtrlIrqEnBit = 2;
   localparam int unsigned CtrlBurstLsb = 4;

   localparam int unsigned StatusBusyBit   = 0;
   localparam int unsigned StatusDoneBit   = 1;
   localparam int unsigned StatusErrBit    = 2;
   localparam int unsigned StatusCfgErrBit = 3;

   localparam logic [31:0] DefaultVersion = 32'h0001_0000;

   typedef struct packed {
      logic cfg_err;
      logic err;
      logic done;
      logic busy;
   } status_t;

   // Replace only the byte lanes enabled in msk.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  msk);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = msk[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_w1c_flag.sv
// Sticky status flag: hardware set, software write-one-to-clear; a coincident set wins.
module dma_w1c_flag (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic set_i,
   input  logic clr_i,
   output logic flag_o
);

   logic flag_d, flag_q;

   always_comb begin
      flag_d = flag_q;
      if (clr_i) flag_d = 1'b0;
      if (set_i) flag_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) flag_q <= 1'b0;
      else         flag_q <= flag_d;
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/dma_reg_bank.sv
// DMA channel register file: configuration registers, start/abort command pulses,
// sticky engine status flags, level interrupt and registered read data.
module dma_reg_bank
   import dma_reg_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned LEN_W   = 24,
   parameter logic [31:0] VERSION = DefaultVersion
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic [11:0]       reg_addr,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [3:0]        wr_msk,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic [ADDR_W-1:0] cfg_src,
   output logic [ADDR_W-1:0] cfg_dst,
   output logic [LEN_W-1:0]  cfg_len,
   output logic [3:0]        cfg_burst,
   output logic              dma_start,
   output logic              dma_abort,
   input  logic              dma_busy,
   input  logic              dma_done,
   input  logic              dma_err,
   input  logic [LEN_W-1:0]  dma_bytes,
   output logic              irq
);

   logic [ADDR_W-1:0] src_d, src_q, dst_d, dst_q;
   logic [LEN_W-1:0]  len_d, len_q;
   logic [3:0]        burst_d, burst_q;
   logic              irq_en_d, irq_en_q;
   logic              start_d, start_q, abort_d, abort_q;
   logic              irq_d, irq_q;
   logic [31:0]       rd_data_d, rd_data_q, rd_mux;
   logic              done_q, err_q, cfg_err_q;
   logic              wr_ctrl, wr_status, cfg_wr_ok, start_req, abort_req, cfg_err_set;
   logic [9:0]        word_addr;
   status_t           status;
   logic              unused_addr_lsb;

   assign word_addr       = reg_addr[11:2];
   assign unused_addr_lsb = ^reg_addr[1:0];

   always_comb begin
      wr_ctrl   = wr_en && (word_addr == CtrlOffset[11:2]) && wr_msk[0];
      wr_status = wr_en && (word_addr == StatusOffset[11:2]) && wr_msk[0];
      // Configuration is frozen while the engine is running.
      cfg_wr_ok = wr_en && !dma_busy;

      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      burst_d  = burst_q;
      irq_en_d = irq_en_q;
      if (cfg_wr_ok && word_addr == SrcOffset[11:2])
         src_d = ADDR_W'(merge_bytes(32'(src_q), wr_data, wr_msk));
      if (cfg_wr_ok && word_addr == DstOffset[11:2])
         dst_d = ADDR_W'(merge_bytes(32'(dst_q), wr_data, wr_msk));
      if (cfg_wr_ok && word_addr == LenOffset[11:2])
         len_d = LEN_W'(merge_bytes(32'(len_q), wr_data, wr_msk));
      if (wr_ctrl && !dma_busy) burst_d = wr_data[CtrlBurstLsb +: 4];
      if (wr_ctrl) irq_en_d = wr_data[CtrlIrqEnBit];

      // ABORT in the same word discards START entirely, including its error check.
      abort_req   = wr_ctrl && wr_data[CtrlAbortBit];
      start_req   = wr_ctrl && wr_data[CtrlStartBit] && !wr_data[CtrlAbortBit];
      start_d     = start_req && !dma_busy && (len_q != '0);
      abort_d     = abort_req && dma_busy;
      cfg_err_set = start_req && (dma_busy || (len_q == '0));

      irq_d = irq_en_q && (done_q || err_q || cfg_err_q);
   end

   dma_w1c_flag u_done_flag (
      .clk_i  (pclk),
      .rst_ni (presetn),
      .set_i  (dma_done),
      .clr_i  (wr_status && wr_data[StatusDoneBit]),
      .flag_o (done_q)
   );

   dma_w1c_flag u_err_flag (
      .clk_i  (pclk),
      .rst_ni (presetn),
      .set_i  (dma_err),
      .clr_i  (wr_status && wr_data[StatusErrBit]),
      .flag_o (err_q)
   );

   dma_w1c_flag u_cfg_err_flag (
      .clk_i  (pclk),
      .rst_ni (presetn),
      .set_i  (cfg_err_set),
      .clr_i  (wr_status && wr_data[StatusCfgErrBit]),
      .flag_o (cfg_err_q)
   );

   always_comb begin
      status = '{cfg_err: cfg_err_q, err: err_q, done: done_q, busy: dma_busy};
      rd_mux = '0;
      case (word_addr)
         CtrlOffset[11:2]: begin
            rd_mux[CtrlIrqEnBit]      = irq_en_q;
            rd_mux[CtrlBurstLsb +: 4] = burst_q;
         end
         StatusOffset[11:2]:  rd_mux = 32'(status);
         SrcOffset[11:2]:     rd_mux = 32'(src_q);
         DstOffset[11:2]:     rd_mux = 32'(dst_q);
         LenOffset[11:2]:     rd_mux = 32'(len_q);
         XferCntOffset[11:2]: rd_mux = 32'(dma_bytes);
         VersionOffset[11:2]: rd_mux = VERSION;
         default:             rd_mux = '0;
      endcase
      rd_data_d = rd_en ? rd_mux : rd_data_q;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         irq_en_q  <= 1'b0;
         start_q   <= 1'b0;
         abort_q   <= 1'b0;
         irq_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         irq_en_q  <= irq_en_d;
         start_q   <= start_d;
         abort_q   <= abort_d;
         irq_q     <= irq_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign cfg_src   = src_q;
   assign cfg_dst   = dst_q;
   assign cfg_len   = len_q;
   assign cfg_burst = burst_q;
   assign dma_start = start_q;
   assign dma_abort = abort_q;
   assign irq       = irq_q;
   assign rd_data   = rd_data_q;

endmodule
